// File: rtl/eth_10g_mac_st_status_ready_adapter.sv
// Avalon-ST timing adapter for the 40-bit 10G MAC status/statistics path.
// The status source has no ready input, so beats are buffered in a small show-ahead FIFO.
// The sink applies backpressure through out_ready. A beat that arrives while the FIFO is full
// and nothing is popping is dropped and flagged on overflow.
//
// Ports:
//   clk, reset_n          single clock, asynchronous active-low reset
//   in_valid/in_data/in_error     source beat (no backpressure to source)
//   out_ready             sink ready, ready latency 0
//   out_valid/out_data/out_error  registered head-of-FIFO beat
//   fill_level            number of stored beats, 0..DEPTH
//   overflow              one-cycle pulse after an incoming beat was dropped
//
// Optional feature (macro ETH_10G_STATUS_DROP_COUNTER_EN):
//   drop_count_clr        synchronous clear of the drop counter
//   drop_count            saturating 16-bit count of dropped beats

module eth_10g_mac_st_status_ready_adapter #(
  parameter int unsigned DATA_W     = 40,
  parameter int unsigned ERR_W      = 7,
  parameter int unsigned DEPTH_LOG2 = 3    // legal range 1..6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [ERR_W-1:0]      in_error,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [ERR_W-1:0]      out_error,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  overflow
`ifdef ETH_10G_STATUS_DROP_COUNTER_EN
  ,
  input  logic                  drop_count_clr,
  output logic [15:0]           drop_count
`endif
);

  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned EntryW = DATA_W + ERR_W;
  localparam int unsigned PtrW   = DEPTH_LOG2 + 1;

  typedef logic [PtrW-1:0]   ptr_t;
  typedef logic [EntryW-1:0] entry_t;

  // Pointers that differ only in the wrap bit mean the FIFO is full.
  localparam ptr_t FullXor = ptr_t'(Depth);

  entry_t mem_q [Depth];

  ptr_t   wptr_q, wptr_d;
  ptr_t   rptr_q, rptr_d;
  ptr_t   fill_q, fill_d;
  logic   out_valid_q, out_valid_d;
  entry_t head_q, head_d;
  logic   overflow_q;

  logic   full;
  logic   pop;
  logic   push;
  logic   drop;

  assign full = ((wptr_q ^ rptr_q) == FullXor);
  assign pop  = out_valid_q & out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the beat.
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  always_comb begin
    rptr_d      = rptr_q + ptr_t'(pop);
    wptr_d      = wptr_q + ptr_t'(push);
    out_valid_d = (rptr_d != wptr_d);

    // Head register is reloaded on the same edge so a continuous sink sees 1 beat/cycle.
    // If the incoming beat lands exactly at the new head slot (FIFO empty after this edge's
    // pop), it bypasses the array; otherwise the head comes from storage. With nothing
    // left, the last value is held.
    head_d = head_q;
    if (push && (wptr_q == rptr_d)) begin
      head_d = {in_data, in_error};
    end else if (out_valid_d) begin
      head_d = mem_q[rptr_d[DEPTH_LOG2-1:0]];
    end

    fill_d = fill_q;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + ptr_t'(1);
      2'b01:   fill_d = fill_q - ptr_t'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= {in_data, in_error};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
      overflow_q  <= drop;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = head_q[EntryW-1:ERR_W];
  assign out_error  = head_q[ERR_W-1:0];
  assign fill_level = fill_q;
  assign overflow   = overflow_q;

`ifdef ETH_10G_STATUS_DROP_COUNTER_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // A clear that coincides with a drop leaves the count at 1, not 0.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_count_clr) begin
      drop_cnt_d = {15'd0, drop};
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
